// File: rtl/alarm_zone_controller.sv
// Multi-zone alarm controller: keypad PIN entry, arm / entry-delay / alarm
// sequencing, sticky zone record and a square-wave siren.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_DISARMED | idle; a correct PIN arms, sensor trips are ignored
// S_ARMED    | watching zones; a trip starts the entry delay
// S_ENTRY    | entry delay running; PIN disarms, wrong PINs use up tries
// S_ALARM    | alert LED on, siren toggling; only a correct PIN leaves
module alarm_zone_controller #(
  parameter int ZONES        = 4,
  parameter int PIN_LEN      = 4,
  parameter int KEY_W        = 4,
  parameter int ENTRY_CYCLES = 50000,
  parameter int SIREN_HALF   = 25000,
  parameter int MAX_TRIES    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ZONES-1:0]                 pir_n,
  input  logic [ZONES-1:0]                 zone_enable,
  input  logic                             key_valid,
  input  logic [KEY_W-1:0]                 key_code,
  input  logic [PIN_LEN*KEY_W-1:0]         pin_code,
  output logic [1:0]                       state,
  output logic                             alerta_pin,
  output logic                             bocina_pin,
  output logic [ZONES-1:0]                 zone_latched,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int EW = (ENTRY_CYCLES > 1) ? $clog2(ENTRY_CYCLES) : 1;
  localparam int SW = (SIREN_HALF > 1) ? $clog2(SIREN_HALF) : 1;
  localparam int IW = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [EW-1:0] ENTRY_LAST = EW'(ENTRY_CYCLES - 1);
  localparam logic [SW-1:0] SIREN_LAST = SW'(SIREN_HALF - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(PIN_LEN - 1);
  localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_ENTRY    = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

  state_t st_q, st_d;
  logic   st_chg;

  logic [ZONES-1:0] pir_s1, pir_s2, trip_vec;
  logic             trip;

  logic [PIN_LEN-1:0][KEY_W-1:0] pin_buf, pin_cand;
  logic [IW-1:0]                 idx;
  logic                          key_clear, key_digit, key_last;
  logic                          match_q, miss_q;

  logic [EW-1:0] ent_cnt;
  logic [SW-1:0] sir_cnt;

  assign state = st_q;

  // two-flop synchroniser for the asynchronous PIR pads, idle high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pir_s1 <= '1;
      pir_s2 <= '1;
    end else begin
      pir_s1 <= pir_n;
      pir_s2 <= pir_s1;
    end
  end

  assign trip_vec  = ~pir_s2 & zone_enable;
  assign trip      = |trip_vec;
  assign key_clear = key_valid && (key_code == {KEY_W{1'b1}});
  assign key_digit = key_valid && !key_clear;
  assign key_last  = key_digit && (idx == IDX_LAST);

  // buffer as it will look once the current digit lands, used for the compare
  always_comb begin
    pin_cand      = pin_buf;
    pin_cand[idx] = key_code;
  end

  // digit capture; the verdict is registered so it acts one edge after the last digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_buf <= '0;
      idx     <= '0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      match_q <= key_last && (pin_cand == pin_code);
      miss_q  <= key_last && (pin_cand != pin_code);
      if (key_digit)
        pin_buf[idx] <= key_code;
      if (st_chg || key_clear || key_last)
        idx <= '0;
      else if (key_digit)
        idx <= idx + IW'(1);
    end
  end

  // next-state: a correct PIN beats alarm entry, which beats a new trip
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_DISARMED: if (match_q) st_d = S_ARMED;
      S_ARMED: begin
        if (match_q)   st_d = S_DISARMED;
        else if (trip) st_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (match_q)
          st_d = S_DISARMED;
        else if ((ent_cnt == ENTRY_LAST) || (miss_q && (tries_left == TW'(1))))
          st_d = S_ALARM;
      end
      S_ALARM: if (match_q) st_d = S_DISARMED;
      default: st_d = S_DISARMED;
    endcase
  end

  assign st_chg = (st_d != st_q);

  // state register and alert LED, both follow the next state directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= S_DISARMED;
      alerta_pin <= 1'b0;
    end else begin
      st_q       <= st_d;
      alerta_pin <= (st_d == S_ALARM);
    end
  end

  // entry-delay counter and siren divider; siren opens with a full high phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_cnt    <= '0;
      sir_cnt    <= '0;
      bocina_pin <= 1'b0;
    end else begin
      if ((st_q == S_ENTRY) && (st_d == S_ENTRY))
        ent_cnt <= ent_cnt + EW'(1);
      else
        ent_cnt <= '0;

      if (st_d != S_ALARM) begin
        sir_cnt    <= '0;
        bocina_pin <= 1'b0;
      end else if (st_q != S_ALARM) begin
        sir_cnt    <= '0;
        bocina_pin <= 1'b1;
      end else if (sir_cnt == SIREN_LAST) begin
        sir_cnt    <= '0;
        bocina_pin <= ~bocina_pin;
      end else begin
        sir_cnt <= sir_cnt + SW'(1);
      end
    end
  end

  // arming clears the zone record and refills the wrong-PIN budget
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zone_latched <= '0;
      tries_left   <= TRIES_INIT;
    end else begin
      if ((st_q == S_DISARMED) && match_q)
        zone_latched <= '0;
      else if ((st_q != S_DISARMED) && trip && !match_q)
        zone_latched <= zone_latched | trip_vec;

      if ((st_q == S_DISARMED) && match_q)
        tries_left <= TRIES_INIT;
      else if ((st_q == S_ENTRY) && miss_q && (tries_left != '0))
        tries_left <= tries_left - TW'(1);
    end
  end

endmodule
